// File: rtl/ptw_req_arbiter_if.sv
// ptw_req_arbiter_if: requester-side and PTW-side handshake bundle for the PTW request arbiter
interface ptw_req_arbiter_if #(
  parameter int N = 2,
  parameter int VPN_W = 27,
  parameter int PPN_W = 54
);
  logic [N-1:0] io_req_valid, io_req_ready, io_resp_valid;
  logic [N*VPN_W-1:0] io_req_vpn;
  logic [PPN_W-1:0] io_resp_pte_ppn, io_ptw_resp_pte_ppn;
  logic io_resp_pte_d, io_resp_pte_a, io_resp_pte_g, io_resp_pte_u;
  logic io_resp_pte_x, io_resp_pte_w, io_resp_pte_r, io_resp_pte_v;
  logic io_resp_ae, io_resp_pf;
  logic io_ptw_req_valid, io_ptw_req_ready;
  logic [VPN_W-1:0] io_ptw_req_vpn;
  logic io_ptw_resp_valid;
  logic io_ptw_resp_pte_d, io_ptw_resp_pte_a, io_ptw_resp_pte_g, io_ptw_resp_pte_u;
  logic io_ptw_resp_pte_x, io_ptw_resp_pte_w, io_ptw_resp_pte_r, io_ptw_resp_pte_v;
  logic io_ptw_resp_ae;
  logic io_busy;
  modport master (
    output io_req_valid, io_req_vpn, io_ptw_req_ready, io_ptw_resp_valid, io_ptw_resp_pte_ppn,
           io_ptw_resp_pte_d, io_ptw_resp_pte_a, io_ptw_resp_pte_g, io_ptw_resp_pte_u,
           io_ptw_resp_pte_x, io_ptw_resp_pte_w, io_ptw_resp_pte_r, io_ptw_resp_pte_v, io_ptw_resp_ae,
    input  io_req_ready, io_resp_valid, io_resp_pte_ppn,
           io_resp_pte_d, io_resp_pte_a, io_resp_pte_g, io_resp_pte_u,
           io_resp_pte_x, io_resp_pte_w, io_resp_pte_r, io_resp_pte_v,
           io_resp_ae, io_resp_pf, io_ptw_req_valid, io_ptw_req_vpn, io_busy
  );
  modport slave (
    input  io_req_valid, io_req_vpn, io_ptw_req_ready, io_ptw_resp_valid, io_ptw_resp_pte_ppn,
           io_ptw_resp_pte_d, io_ptw_resp_pte_a, io_ptw_resp_pte_g, io_ptw_resp_pte_u,
           io_ptw_resp_pte_x, io_ptw_resp_pte_w, io_ptw_resp_pte_r, io_ptw_resp_pte_v, io_ptw_resp_ae,
    output io_req_ready, io_resp_valid, io_resp_pte_ppn,
           io_resp_pte_d, io_resp_pte_a, io_resp_pte_g, io_resp_pte_u,
           io_resp_pte_x, io_resp_pte_w, io_resp_pte_r, io_resp_pte_v,
           io_resp_ae, io_resp_pf, io_ptw_req_valid, io_ptw_req_vpn, io_busy
  );
endinterface

// File: rtl/ptw_req_arbiter.sv
// ptw_req_arbiter: round-robin sharing of one page-table walker among N TLB requesters
module ptw_req_arbiter #(
  parameter int N = 2,
  parameter int VPN_W = 27,
  parameter int PPN_W = 54
) (
  input logic clock,
  input logic reset,
  ptw_req_arbiter_if.slave bus
);
  localparam int PW = $clog2(N);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [PW-1:0] p, owner, winner;
  logic found;
  logic [VPN_W-1:0] vpn;
  logic [PPN_W-1:0] ppn;
  logic [7:0] flags;
  logic ae, pf;
  always_comb begin
    found = 1'b0;
    winner = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.io_req_valid[(int'(p) + k) % N]) begin
        found = 1'b1;
        winner = PW'((int'(p) + k) % N);
      end
    end
  end
  assign bus.io_req_ready = (state == IDLE && found) ? N'(1) << winner : '0;
  assign bus.io_resp_valid = (state == RESP) ? N'(1) << owner : '0;
  assign bus.io_ptw_req_valid = state == ISSUE;
  assign bus.io_ptw_req_vpn = vpn;
  assign bus.io_busy = state != IDLE;
  assign bus.io_resp_pte_ppn = ppn;
  assign {bus.io_resp_pte_d, bus.io_resp_pte_a, bus.io_resp_pte_g, bus.io_resp_pte_u,
          bus.io_resp_pte_x, bus.io_resp_pte_w, bus.io_resp_pte_r, bus.io_resp_pte_v} = flags;
  assign bus.io_resp_ae = ae;
  assign bus.io_resp_pf = pf;
  // pf is registered at capture so it reads 0 out of reset rather than ~v
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      p <= '0;
      owner <= '0;
      vpn <= '0;
      ppn <= '0;
      flags <= '0;
      ae <= 1'b0;
      pf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          vpn <= bus.io_req_vpn[winner*VPN_W +: VPN_W];
          owner <= winner;
          p <= (winner == PW'(N-1)) ? '0 : winner + 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (bus.io_ptw_req_ready) state <= WAIT;
        WAIT: if (bus.io_ptw_resp_valid) begin
          ppn <= bus.io_ptw_resp_pte_ppn;
          flags <= {bus.io_ptw_resp_pte_d, bus.io_ptw_resp_pte_a, bus.io_ptw_resp_pte_g,
                    bus.io_ptw_resp_pte_u, bus.io_ptw_resp_pte_x, bus.io_ptw_resp_pte_w,
                    bus.io_ptw_resp_pte_r, bus.io_ptw_resp_pte_v};
          ae <= bus.io_ptw_resp_ae;
          pf <= ~bus.io_ptw_resp_pte_v | (bus.io_ptw_resp_pte_w & ~bus.io_ptw_resp_pte_r);
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ptw_req_arbiter.sv
// tb_ptw_req_arbiter: randomized transaction-level checking of the PTW request arbiter
module tb_ptw_req_arbiter;
  localparam int N = 2, VPN_W = 27, PPN_W = 54;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0, rr = 0;
  int grants[$];
  ptw_req_arbiter_if #(.N(N), .VPN_W(VPN_W), .PPN_W(PPN_W)) bus();
  ptw_req_arbiter #(.N(N), .VPN_W(VPN_W), .PPN_W(PPN_W)) dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  // flag vectors are ordered {d,a,g,u,x,w,r,v}
  wire [7:0] flags_o = {bus.io_resp_pte_d, bus.io_resp_pte_a, bus.io_resp_pte_g, bus.io_resp_pte_u,
                        bus.io_resp_pte_x, bus.io_resp_pte_w, bus.io_resp_pte_r, bus.io_resp_pte_v};
  wire [N+N+PPN_W+8+2+1+VPN_W+1-1:0] all_o = {bus.io_req_ready, bus.io_resp_valid, bus.io_resp_pte_ppn,
    flags_o, bus.io_resp_ae, bus.io_resp_pf, bus.io_ptw_req_valid, bus.io_ptw_req_vpn, bus.io_busy};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pte(input logic [PPN_W-1:0] ppn, input logic [7:0] f, input logic ae);
    bus.io_ptw_resp_pte_ppn = ppn;
    {bus.io_ptw_resp_pte_d, bus.io_ptw_resp_pte_a, bus.io_ptw_resp_pte_g, bus.io_ptw_resp_pte_u,
     bus.io_ptw_resp_pte_x, bus.io_ptw_resp_pte_w, bus.io_ptw_resp_pte_r, bus.io_ptw_resp_pte_v} = f;
    bus.io_ptw_resp_ae = ae;
  endtask

  task automatic drive_junk;
    drive_pte(PPN_W'({$urandom, $urandom}), 8'($urandom), 1'($urandom));
  endtask

  task automatic run_walk(input logic [N-1:0] reqv, input logic [N*VPN_W-1:0] vpns, input int rdly,
                          input int wdly, input logic [PPN_W-1:0] ppn, input logic [7:0] f,
                          input logic ae, input bit spur, input bit noisy);
    int win;
    logic [VPN_W-1:0] ev;
    logic [N-1:0] er;
    logic epf;
    win = -1;
    for (int k = 0; k < N; k++) if (win < 0 && reqv[(rr + k) % N]) win = (rr + k) % N;
    ev = vpns[win*VPN_W +: VPN_W];
    er = '0;
    er[win] = 1'b1;
    epf = !f[0] || (f[2] && !f[1]);
    bus.io_req_valid = reqv;
    bus.io_req_vpn = vpns;
    bus.io_ptw_req_ready = 1'b0;
    bus.io_ptw_resp_valid = 1'b0;
    #1;
    checks++;
    if (bus.io_req_ready !== er) begin
      errors++;
      $display("FAIL grant: got %b want %b", bus.io_req_ready, er);
    end
    checks++;
    if (bus.io_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle: got %b want 0", bus.io_busy);
    end
    for (int k = 0; k < N; k++) if (bus.io_req_ready[k]) grants.push_back(k);
    tick;
    rr = (win + 1) % N;
    for (int d = 0; d <= rdly; d++) begin
      if (noisy) bus.io_req_valid = N'($urandom);
      bus.io_ptw_req_ready = (d == rdly);
      bus.io_ptw_resp_valid = spur;
      if (spur) drive_junk();
      #1;
      checks++;
      if ({bus.io_ptw_req_valid, bus.io_ptw_req_vpn} !== {1'b1, ev}) begin
        errors++;
        $display("FAIL ptw_req: got valid=%b vpn=%h want valid=1 vpn=%h", bus.io_ptw_req_valid, bus.io_ptw_req_vpn, ev);
      end
      checks++;
      if (bus.io_req_ready !== '0 || bus.io_resp_valid !== '0 || bus.io_busy !== 1'b1) begin
        errors++;
        $display("FAIL issue_quiet: got ready=%b resp=%b busy=%b want 0 0 1", bus.io_req_ready, bus.io_resp_valid, bus.io_busy);
      end
      tick;
    end
    bus.io_ptw_req_ready = 1'b0;
    for (int d = 0; d <= wdly; d++) begin
      if (noisy) bus.io_req_valid = N'($urandom);
      bus.io_ptw_resp_valid = (d == wdly);
      if (d == wdly) drive_pte(ppn, f, ae); else drive_junk();
      #1;
      checks++;
      if (bus.io_ptw_req_valid !== 1'b0 || bus.io_resp_valid !== '0 || bus.io_req_ready !== '0) begin
        errors++;
        $display("FAIL wait_quiet: got ptw_req=%b resp=%b ready=%b want 0 0 0", bus.io_ptw_req_valid, bus.io_resp_valid, bus.io_req_ready);
      end
      tick;
    end
    bus.io_ptw_resp_valid = 1'b0;
    bus.io_req_valid = '0;
    drive_junk();
    #1;
    checks++;
    if (bus.io_resp_valid !== er) begin
      errors++;
      $display("FAIL resp_valid: got %b want %b", bus.io_resp_valid, er);
    end
    checks++;
    if ({bus.io_resp_pte_ppn, flags_o, bus.io_resp_ae, bus.io_resp_pf} !== {ppn, f, ae, epf}) begin
      errors++;
      $display("FAIL resp_fields: got ppn=%h f=%b ae=%b pf=%b want ppn=%h f=%b ae=%b pf=%b",
               bus.io_resp_pte_ppn, flags_o, bus.io_resp_ae, bus.io_resp_pf, ppn, f, ae, epf);
    end
    tick;
    checks++;
    if (bus.io_resp_valid !== '0 || bus.io_busy !== 1'b0 || {bus.io_resp_pte_ppn, bus.io_resp_pf} !== {ppn, epf}) begin
      errors++;
      $display("FAIL after_resp: got resp=%b busy=%b ppn=%h pf=%b want 0 0 %h %b",
               bus.io_resp_valid, bus.io_busy, bus.io_resp_pte_ppn, bus.io_resp_pf, ppn, epf);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.io_req_valid = '0;
    bus.io_req_vpn = '0;
    bus.io_ptw_req_ready = 1'b0;
    bus.io_ptw_resp_valid = 1'b0;
    drive_pte('0, '0, 1'b0);
    repeat (3) tick;
    checks++;
    if (all_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", all_o);
    end
    rst = 1'b0;
    rr = 0;
    tick;
    checks++;
    if (bus.io_req_ready !== '0 || bus.io_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got ready=%b busy=%b want 0 0", bus.io_req_ready, bus.io_busy);
    end
  endtask

  task automatic test_single_walk;
    run_walk(2'b01, {VPN_W'($urandom), VPN_W'('h1234)}, 0, 0, PPN_W'('hABCDE), 8'b0000_1011, 1'b0, 0, 0);
  endtask

  task automatic test_fairness;
    test_reset();
    grants.delete();
    for (int i = 0; i < 4; i++)
      run_walk(2'b11, {VPN_W'($urandom), VPN_W'($urandom)}, 0, 0, PPN_W'({$urandom, $urandom}), 8'($urandom), 1'b0, 0, 0);
    checks++;
    if (grants.size() != 4) begin
      errors++;
      $display("FAIL fair_count: got %0d grants want 4", grants.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      checks++;
      if (grants[i] != i % 2) begin
        errors++;
        $display("FAIL fair_order[%0d]: got %0d want %0d", i, grants[i], i % 2);
      end
    end
  endtask

  task automatic test_page_fault;
    run_walk(2'b01, {VPN_W'($urandom), VPN_W'($urandom)}, 0, 1, PPN_W'('h111), 8'b0000_0101, 1'b0, 0, 0);
    run_walk(2'b10, {VPN_W'($urandom), VPN_W'($urandom)}, 0, 0, PPN_W'('h222), 8'b0000_1010, 1'b0, 0, 0);
    run_walk(2'b11, {VPN_W'($urandom), VPN_W'($urandom)}, 1, 0, PPN_W'('h333), 8'b0000_0111, 1'b1, 0, 0);
  endtask

  task automatic test_backpressure;
    run_walk(2'b10, {VPN_W'('h5A5A5), VPN_W'($urandom)}, 5, 2, PPN_W'('h444), 8'b1100_0011, 1'b0, 1, 1);
  endtask

  task automatic test_reset_in_wait;
    bus.io_req_valid = 2'b10;
    bus.io_req_vpn = {VPN_W'('h777), VPN_W'('h888)};
    bus.io_ptw_req_ready = 1'b1;
    tick;
    tick;
    bus.io_req_valid = '0;
    bus.io_ptw_req_ready = 1'b0;
    checks++;
    if (bus.io_busy !== 1'b1 || bus.io_ptw_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL enter_wait: got busy=%b ptw_req=%b want 1 0", bus.io_busy, bus.io_ptw_req_valid);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    rr = 0;
    checks++;
    if (all_o !== '0) begin
      errors++;
      $display("FAIL wait_reset_outputs: got %h want 0", all_o);
    end
    bus.io_ptw_resp_valid = 1'b1;
    drive_pte(PPN_W'('hFFFFF), 8'hFF, 1'b1);
    tick;
    bus.io_ptw_resp_valid = 1'b0;
    checks++;
    if (all_o !== '0) begin
      errors++;
      $display("FAIL late_resp_dropped: got %h want 0", all_o);
    end
    tick;
    checks++;
    if (bus.io_resp_valid !== '0 || bus.io_busy !== 1'b0) begin
      errors++;
      $display("FAIL late_resp_idle: got resp=%b busy=%b want 0 0", bus.io_resp_valid, bus.io_busy);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      run_walk(N'($urandom_range(1, 3)), {VPN_W'($urandom), VPN_W'($urandom)}, $urandom_range(0, 3),
               $urandom_range(0, 3), PPN_W'({$urandom, $urandom}), 8'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_single_walk();
    test_fairness();
    test_page_fault();
    test_backpressure();
    test_reset_in_wait();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++)
      run_walk(2'b11, {VPN_W'($urandom), VPN_W'($urandom)}, 0, 0, PPN_W'(i + 1), 8'b0000_0011, 1'b0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end
endmodule

// File: doc/ptw_req_arbiter.md
# ptw_req_arbiter

Shares one page-table walker (PTW) between N TLB requesters, with one walk outstanding at a time. Accepts a VPN from a round-robin-selected requester and issues it to the PTW. Captures the returned PTE (ppn, d, a, g, u, x, w, r, v, access-exception) and pulses a one-hot response back to the owning requester. Sits between the ITLB/DTLB request ports and the PTW request/response port, on the PTE path that feeds the TLB refill barrier.

## Interface
- N, default 2: number of requesters, range 2..8.
- VPN_W, default 27: virtual page number width.
- PPN_W, default 54: PTE ppn width.

- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- io_req_valid  in  N  per-requester walk request.
- io_req_ready  out  N  per-requester accept; at most one bit set.
- io_req_vpn  in  N*VPN_W  requester i at [i*VPN_W +: VPN_W].
- io_resp_valid  out  N  one-cycle one-hot response pulse to the owner.
- io_resp_pte_ppn  out  PPN_W  captured PTE ppn, broadcast to all requesters.
- io_resp_pte_d/a/g/u/x/w/r/v  out  1 each  captured PTE flags.
- io_resp_ae  out  1  captured access exception.
- io_resp_pf  out  1  page fault derived from the captured PTE.
- io_ptw_req_valid  out  1  walk request to the PTW.
- io_ptw_req_ready  in  1  PTW accept.
- io_ptw_req_vpn  out  VPN_W  latched VPN.
- io_ptw_resp_valid  in  1  PTW result valid.
- io_ptw_resp_pte_ppn, io_ptw_resp_pte_d/a/g/u/x/w/r/v, io_ptw_resp_ae  in  PPN_W / 1 each  PTW result.
- io_busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- Round-robin pointer p, width clog2(N), reset 0.
- IDLE:
  - Winner is the first set bit of io_req_valid, scanning p, p+1, …, N-1, 0, …, wrapping.
  - io_req_ready[winner]=1 combinationally; all other ready bits are 0. If no requester is valid, all ready bits are 0.
  - On handshake: latch the VPN and owner = winner, set p = (winner+1) mod N, go to ISSUE.
- ISSUE:
  - io_ptw_req_valid=1 and io_ptw_req_vpn = latched VPN, both held stable until io_ptw_req_ready.
  - On handshake go to WAIT.
  - All io_req_ready bits are 0 in ISSUE, WAIT and RESP.
- WAIT:
  - On io_ptw_resp_valid: capture all PTE fields and ae into registers, go to RESP.
- RESP:
  - io_resp_valid[owner]=1 for exactly one cycle, then go to IDLE.
- Page fault: io_resp_pf = ~v | (w & ~r), computed from the captured registers.
- Response field outputs, including pf, stay at their captured values until the next capture. They are meaningful only while io_resp_valid is set.
- io_ptw_resp_valid outside WAIT, including the ISSUE handshake cycle, is ignored: no capture and no state change.
- Reset:
  - State goes to IDLE; p and owner go to 0.
  - All captured PTE registers, io_resp_pf and latched VPN go to 0.
  - All outputs go to 0.
  - Reset mid-walk abandons the walk. Later PTW responses are dropped, because the block is not in WAIT.

## Timing
- Request handshake at cycle t gives io_ptw_req_valid at t+1.
- PTW request handshake at cycle u; earliest io_ptw_resp_valid that is accepted is at u+1.
- io_ptw_resp_valid accepted at cycle w gives io_resp_valid at w+1.
- Minimum accept-to-response latency is 3 cycles; the next request can be accepted at w+2.
- Registered outputs: io_ptw_req_valid/vpn, io_resp_valid and the resp fields are functions of registered state only.
- io_req_ready is combinational from io_req_valid and p.
- Requesters may deassert io_req_valid before ready with no side effect.

## Test plan
- Reset for 3 cycles with all inputs at 0 -> every output is 0 and io_busy=0. With io_req_valid=0 in IDLE, io_req_ready=0.
- Single walk, zero wait states:
  - Stimulus: requester 0 presents vpn 0x1234 with io_ptw_req_ready=1; PTW returns ppn 0xABCDE, v=1, r=1, x=1 one cycle after accepting the request.
  - Response: io_ptw_req_vpn=0x1234 at t+1; io_resp_valid=2'b01 at t+3; ppn=0xABCDE; pf=0; ae=0.
- Fairness:
  - Stimulus: both requesters valid continuously from reset, with N=2.
  - Response: grants in order 0, 1, 0, 1. p wraps 1 -> 0, and each io_resp_valid pulse goes to the matching owner.
- Page fault decode:
  - PTE v=1, w=1, r=0 -> io_resp_pf=1.
  - PTE v=0 -> io_resp_pf=1.
  - PTE v=1, r=1, w=1, with ae=1 from the PTW -> pf=0, ae=1.
- Backpressure:
  - Stimulus: io_ptw_req_ready held 0 for 5 cycles while requester 1 waits.
  - Response: io_ptw_req_valid stays 1 with a stable VPN; io_req_ready stays 0; a spurious io_ptw_resp_valid pulse during this time is ignored.
- Reset in WAIT:
  - Stimulus: assert reset for 1 cycle while in WAIT, then pulse io_ptw_resp_valid.
  - Response: the block is in IDLE after reset, io_resp_valid stays 0, and the PTE outputs remain 0.
